// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - lsu_state_e : control FSM states (IDLE, XFER, RESP)
//   - F3_*        : RV32I load/store funct3 encodings
//   - size_bytes  : funct3 -> access size in bytes (0 for an unusable width code)
//   - f3_legal    : whether a funct3 is a legal load or store encoding
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // The low two funct3 bits carry the access width for every RV32I load/store.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic f3_legal(input logic is_store, input logic [2:0] funct3);
    if (is_store)
      return funct3 inside {F3_SB, F3_SH, F3_SW};
    return funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// -----------------------------------------------------------------------------
// lsu_extend
// Combinational sign/zero extension of the assembled load word.
// Ports:
//   funct3_i : load funct3 (LB/LH sign-extend, LBU/LHU zero-extend, LW as-is)
//   word_i   : assembled little-endian load word (unused upper bytes are 0)
//   data_o   : extended 32-bit result
// -----------------------------------------------------------------------------
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (funct3_i)
      F3_LB:   data_o = {{24{word_i[7]}}, word_i[7:0]};
      F3_LH:   data_o = {{16{word_i[15]}}, word_i[15:0]};
      F3_LBU:  data_o = {24'd0, word_i[7:0]};
      F3_LHU:  data_o = {16'd0, word_i[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Multi-beat load/store engine: accepts one LOAD/STORE per valid/ready
// handshake, splits it into BUS_W-wide beats over a req/ack memory handshake
// (any number of wait states), assembles and extends load data and returns a
// single-cycle response.
//
// Parameters: BUS_W (8/16/32, BB = BUS_W/8 lanes per beat), ADDR_W.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_req_*/o_req_ready    request handshake (store flag, funct3, addr, wdata, rd)
//   o_rsp_*                one-cycle response (valid, rd, data, err)
//   o_mem_* / i_mem_*      beat request, ack, address, write, byte enables, data
//
// Build option: define MISALIGN_TRAP_EN to reject accesses whose address is
// not a multiple of the access size (error response, no memory traffic).
// Without it misaligned accesses are performed as ordinary multi-lane beats.
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int BUS_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_store,
  input  logic [2:0]           i_req_funct3,
  input  logic [ADDR_W-1:0]    i_req_addr,
  input  logic [31:0]          i_req_wdata,
  input  logic [4:0]           i_req_rd,
  output logic                 o_rsp_valid,
  output logic [4:0]           o_rsp_rd,
  output logic [31:0]          o_rsp_data,
  output logic                 o_rsp_err,
  output logic                 o_mem_req,
  input  logic                 i_mem_ack,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic                 o_mem_write,
  output logic [BUS_W/8-1:0]   o_mem_be,
  output logic [BUS_W-1:0]     o_mem_data,
  input  logic [BUS_W-1:0]     i_mem_data
);

  localparam int BB = BUS_W / 8;

  lsu_state_e          state_q, state_d;
  logic                store_q, store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [4:0]          rd_q, rd_d;
  logic [2:0]          beat_q, beat_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                accept;
  logic                req_err;
  logic [2:0]          req_size;
  logic [2:0]          size;
  logic [2:0]          n_beats;
  logic                last_beat;
  logic [31:0]         ext_data;
  int                  rd_idx;
  int                  wr_idx;

  assign accept    = i_req_valid && (state_q == IDLE);
  assign size      = size_bytes(funct3_q);
  assign n_beats   = 3'((32'(size) + 32'(BB) - 32'd1) / 32'(BB));
  assign last_beat = (beat_q == n_beats - 3'd1);

  // Errors are decided at accept time from the live request so the FSM can
  // go straight to RESP without touching memory.
  always_comb begin
    req_size = size_bytes(i_req_funct3);
    req_err  = !f3_legal(i_req_store, i_req_funct3);
`ifdef MISALIGN_TRAP_EN
    // size-1 masks the address bits that must be zero (size 4 -> 2'b11).
    if ((i_req_addr[1:0] & (req_size[1:0] - 2'd1)) != 2'b00)
      req_err = 1'b1;
`else
    req_err  = req_err || (req_size == 3'd0);
`endif
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs regardless of process order.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : XFER;
      XFER:    if (i_mem_ack && last_beat) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture, beat counter and load-data assembly
  // ---------------------------------------------------------------------------
  always_comb begin
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rd_idx   = 0;
    if (accept) begin
      store_d  = i_req_store;
      funct3_d = i_req_funct3;
      addr_d   = i_req_addr;
      wdata_d  = i_req_wdata;
      rd_d     = i_req_rd;
      beat_d   = 3'd0;
      rdata_d  = 32'd0;
      err_d    = req_err;
    end else if (state_q == XFER && i_mem_ack) begin
      // Lane l of beat k holds request byte k*BB+l; lanes past the access are dropped.
      for (int l = 0; l < BB; l++) begin
        rd_idx = int'(beat_q) * BB + l;
        if (rd_idx < int'(size))
          rdata_d[rd_idx*8 +: 8] = i_mem_data[l*8 +: 8];
      end
      beat_d = beat_q + 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rd_q     <= 5'd0;
      beat_q   <= 3'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  lsu_extend u_extend (
    .funct3_i (funct3_q),
    .word_i   (rdata_q),
    .data_o   (ext_data)
  );

  // ---------------------------------------------------------------------------
  // Outputs: pure functions of registered state, hence stable through waits
  // ---------------------------------------------------------------------------
  always_comb begin
    o_req_ready = (state_q == IDLE);
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_mem_write = 1'b0;
    o_mem_be    = '0;
    o_mem_data  = '0;
    o_rsp_valid = 1'b0;
    o_rsp_rd    = 5'd0;
    o_rsp_data  = 32'd0;
    o_rsp_err   = 1'b0;
    wr_idx      = 0;
    unique case (state_q)
      XFER: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = addr_q + ADDR_W'(beat_q) * ADDR_W'(BB);
        o_mem_write = store_q;
        for (int l = 0; l < BB; l++) begin
          wr_idx = int'(beat_q) * BB + l;
          if (wr_idx < int'(size)) begin
            o_mem_be[l]         = 1'b1;
            o_mem_data[l*8 +: 8] = wdata_q[wr_idx*8 +: 8];
          end
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = err_q;
        if (!err_q && !store_q) begin
          o_rsp_rd   = rd_q;
          o_rsp_data = ext_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit (BUS_W = 8). A byte-addressed memory
// model supplies load data and absorbs stores; expected beats and responses
// are derived from access size, lane coverage and RV32I extension rules.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int BUS_W  = 8;
  localparam int ADDR_W = 32;
  localparam int BB     = BUS_W / 8;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_store;
  logic [2:0]        i_req_funct3;
  logic [ADDR_W-1:0] i_req_addr;
  logic [31:0]       i_req_wdata;
  logic [4:0]        i_req_rd;
  logic              o_rsp_valid;
  logic [4:0]        o_rsp_rd;
  logic [31:0]       o_rsp_data;
  logic              o_rsp_err;
  logic              o_mem_req;
  logic              i_mem_ack;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_write;
  logic [BB-1:0]     o_mem_be;
  logic [BUS_W-1:0]  o_mem_data;
  logic [BUS_W-1:0]  i_mem_data;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  load_store_unit #(.BUS_W(BUS_W), .ADDR_W(ADDR_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_store  (i_req_store),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .i_req_rd     (i_req_rd),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rd     (o_rsp_rd),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_err    (o_rsp_err),
    .o_mem_req    (o_mem_req),
    .i_mem_ack    (i_mem_ack),
    .o_mem_addr   (o_mem_addr),
    .o_mem_write  (o_mem_write),
    .o_mem_be     (o_mem_be),
    .o_mem_data   (o_mem_data),
    .i_mem_data   (i_mem_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_legal(input logic st, input logic [2:0] f3);
    if (st) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned raw = 0;
    int s = acc_size(f3);
    for (int i = 0; i < s; i++) raw += int'(mem_rd(addr + 32'(i))) << (8 * i);
    case (f3)
      3'd0:    return (raw >= 128)   ? raw + 32'hFFFF_FF00 : raw;  // LB
      3'd1:    return (raw >= 32768) ? raw + 32'hFFFF_0000 : raw;  // LH
      default: return raw;                                          // LW/LBU/LHU
    endcase
  endfunction

  task automatic garble_req();
    i_req_valid  = 1'($urandom);
    i_req_store  = 1'($urandom);
    i_req_funct3 = 3'($urandom);
    i_req_addr   = $urandom;
    i_req_wdata  = $urandom;
    i_req_rd     = 5'($urandom);
  endtask

  // Runs one request starting at a negedge with the unit idle and returns at
  // the negedge one cycle after the response (unit idle again).
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int waits,
                         output logic [31:0] seen);
    int          s, nb;
    bit          exp_err;
    logic [31:0] exp_data, baddr;
    logic [4:0]  exp_rd;
    logic [BB-1:0]    exp_be;
    logic [BUS_W-1:0] exp_wd, lane_mask;
    s       = acc_size(f3);
    exp_err = !is_legal(st, f3);
`ifdef MISALIGN_TRAP_EN
    if (!exp_err && (addr % s) != 0) exp_err = 1'b1;
`endif
    exp_data = (!exp_err && !st) ? model_load(f3, addr) : 32'd0;
    exp_rd   = (!exp_err && !st) ? rd : 5'd0;
    nb       = exp_err ? 0 : (s + BB - 1) / BB;

    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    i_req_valid  = 1'b1;
    i_req_store  = st;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wd;
    i_req_rd     = rd;
    i_mem_ack    = 1'($urandom);
    i_mem_data   = BUS_W'($urandom);
    @(posedge i_clk);
    @(negedge i_clk);

    for (int k = 0; k < nb; k++) begin
      baddr = addr + 32'(k * BB);
      exp_be = '0;
      exp_wd = '0;
      for (int l = 0; l < BB; l++)
        if (k * BB + l < s) begin
          exp_be[l] = 1'b1;
          exp_wd[l*8 +: 8] = wd[(k*BB+l)*8 +: 8];
        end
      lane_mask = '0;
      for (int l = 0; l < BB; l++) if (exp_be[l]) lane_mask[l*8 +: 8] = 8'hFF;
      for (int w = 0; w <= waits; w++) begin
        check("mem_req",     32'(o_mem_req), 32'd1);
        check("mem_addr",    o_mem_addr, baddr);
        check("mem_write",   32'(o_mem_write), 32'(st));
        check("mem_be",      32'(o_mem_be), 32'(exp_be));
        if (st) check("mem_wdata", 32'(o_mem_data & lane_mask), 32'(exp_wd));
        check("ready_busy",  32'(o_req_ready), 32'd0);
        check("rsp_early",   32'(o_rsp_valid), 32'd0);
        garble_req();
        if (w == waits) begin
          i_mem_ack = 1'b1;
          for (int l = 0; l < BB; l++) begin
            if (st && exp_be[l]) mem[baddr + 32'(l)] = exp_wd[l*8 +: 8];
            i_mem_data[l*8 +: 8] = st ? 8'($urandom) : mem_rd(baddr + 32'(l));
          end
        end else begin
          i_mem_ack  = 1'b0;
          i_mem_data = BUS_W'($urandom);
        end
        @(posedge i_clk);
        @(negedge i_clk);
      end
    end

    // Response cycle
    garble_req();
    i_mem_ack  = 1'($urandom);
    i_mem_data = BUS_W'($urandom);
    check("rsp_valid",   32'(o_rsp_valid), 32'd1);
    check("rsp_err",     32'(o_rsp_err), 32'(exp_err));
    check("rsp_rd",      32'(o_rsp_rd), 32'(exp_rd));
    check("rsp_data",    o_rsp_data, exp_data);
    check("rsp_no_mem",  32'(o_mem_req), 32'd0);
    seen = o_rsp_data;
    @(posedge i_clk);
    @(negedge i_clk);
    check("rsp_drop",    32'(o_rsp_valid), 32'd0);
    check("rsp_data_0",  o_rsp_data, 32'd0);
    check("rsp_err_0",   32'(o_rsp_err), 32'd0);
    check("ready_back",  32'(o_req_ready), 32'd1);
    i_req_valid = 1'b0;
    i_mem_ack   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : main
    logic [31:0] seen;
    logic [2:0]  f3;
    logic        st;
    i_rst = 1'b1;
    i_req_valid = 1'b0; i_req_store = 1'b0; i_req_funct3 = 3'd0;
    i_req_addr = '0; i_req_wdata = '0; i_req_rd = '0;
    i_mem_ack = 1'b0; i_mem_data = '0;
    repeat (3) @(negedge i_clk);
    check("rst_ready",    32'(o_req_ready), 32'd1);
    check("rst_mem_req",  32'(o_mem_req), 32'd0);
    check("rst_rsp",      32'(o_rsp_valid), 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_be",       32'(o_mem_be), 32'd0);
    check("rst_rsp_data", o_rsp_data, 32'd0);
    i_rst = 1'b0;

    // LW from 0x100 with bytes 78 56 34 12, no waits
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    run_txn(1'b0, 3'd2, 32'h100, 32'h0, 5'd3, 0, seen);
    check("lw_0x100", seen, 32'h1234_5678);

    // LB / LBU of 0x80
    mem[32'h200] = 8'h80;
    run_txn(1'b0, 3'd0, 32'h200, 32'h0, 5'd7, 0, seen);
    check("lb_sext", seen, 32'hFFFF_FF80);
    run_txn(1'b0, 3'd4, 32'h200, 32'h0, 5'd7, 1, seen);
    check("lbu_zext", seen, 32'h0000_0080);

    // SH then read back with LH / LHU
    run_txn(1'b1, 3'd1, 32'h302, 32'hDEAD_BEEF, 5'd9, 0, seen);
    run_txn(1'b0, 3'd1, 32'h302, 32'h0, 5'd10, 2, seen);
    check("sh_lh_back", seen, 32'hFFFF_BEEF);
    run_txn(1'b0, 3'd5, 32'h302, 32'h0, 5'd11, 0, seen);
    check("sh_lhu_back", seen, 32'h0000_BEEF);

    // LH with three wait states per beat
    mem[32'h10] = 8'h34; mem[32'h11] = 8'h92;
    run_txn(1'b0, 3'd1, 32'h10, 32'h0, 5'd12, 3, seen);
    check("lh_waits", seen, 32'hFFFF_9234);

    // Illegal encodings
    run_txn(1'b0, 3'd3, 32'h40, 32'h0, 5'd4, 0, seen);
    run_txn(1'b1, 3'd4, 32'h44, 32'h1234, 5'd4, 0, seen);

    // Misaligned LW (trap or four byte beats depending on build)
    run_txn(1'b0, 3'd2, 32'h101, 32'h0, 5'd5, 0, seen);

    // Reset during beat 2 of an LW
    i_req_valid = 1'b1; i_req_store = 1'b0; i_req_funct3 = 3'd2;
    i_req_addr = 32'h400; i_req_rd = 5'd6;
    @(posedge i_clk); @(negedge i_clk);
    i_req_valid = 1'b0;
    i_mem_ack = 1'b1; i_mem_data = BUS_W'($urandom);
    repeat (2) begin @(posedge i_clk); @(negedge i_clk); end
    check("rstx_beat2_addr", o_mem_addr, 32'h402);
    i_rst = 1'b1; i_mem_ack = 1'b0;
    @(posedge i_clk); @(negedge i_clk);
    check("rstx_mem_req", 32'(o_mem_req), 32'd0);
    check("rstx_ready",   32'(o_req_ready), 32'd1);
    check("rstx_rsp",     32'(o_rsp_valid), 32'd0);
    i_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      i_mem_ack = 1'($urandom);
      @(posedge i_clk); @(negedge i_clk);
      check("rstx_no_rsp", 32'(o_rsp_valid), 32'd0);
      check("idle_ack_ignored", 32'(o_mem_req), 32'd0);
    end
    i_mem_ack = 1'b0;

    // Randomized traffic in a small window so loads see earlier stores
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom);
      if ($urandom_range(7) == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom_range(2));
      else begin
        case ($urandom_range(4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end
      run_txn(st, f3, 32'h1000 + 32'($urandom_range(63)), $urandom,
              5'($urandom), $urandom_range(2), seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
